// File: rtl/fine_delay_interp_if.sv
// ---------------------------------------------------------------------------
// fine_delay_interp_if
//   Bundles the sample stream, line control and fine-delay LUT write port of
//   one fine-delay channel.
//
//   Signals:
//     tx_en           transmit active; input samples are ignored while high
//     start           scanline receive window, high for the whole line
//     fine_din        signed coarse-delayed sample
//     fine_din_valid  fine_din qualifier
//     lut_addr        fine-delay LUT write address
//     lut_we          fine-delay LUT write enable
//     lut_din         unsigned fraction to write
//     fine_dout       signed interpolated sample, FRAC_WD fractional bits
//     fine_dout_valid fine_dout qualifier
//
//   Modports:
//     master  upstream side (drives stream/control/LUT, receives output)
//     slave   the fine-delay stage itself
// ---------------------------------------------------------------------------
interface fine_delay_interp_if #(
  parameter int INPUT_WD  = 14,
  parameter int FRAC_WD   = 4,
  parameter int ADDR_WD   = 12,
  parameter int FD_OUT_WD = 18
) ();

  logic                        tx_en;
  logic                        start;
  logic signed [INPUT_WD-1:0]  fine_din;
  logic                        fine_din_valid;
  logic        [ADDR_WD-1:0]   lut_addr;
  logic                        lut_we;
  logic        [FRAC_WD-1:0]   lut_din;
  logic signed [FD_OUT_WD-1:0] fine_dout;
  logic                        fine_dout_valid;

  modport master (
    output tx_en, start, fine_din, fine_din_valid, lut_addr, lut_we, lut_din,
    input  fine_dout, fine_dout_valid
  );

  modport slave (
    input  tx_en, start, fine_din, fine_din_valid, lut_addr, lut_we, lut_din,
    output fine_dout, fine_dout_valid
  );

endinterface

// File: rtl/fine_delay_interp.sv
// ---------------------------------------------------------------------------
// fine_delay_interp
//   Per-channel fine-delay stage. Each accepted coarse-delayed sample x is
//   linearly interpolated with the previous accepted sample p using a
//   fraction f read from a writable LUT indexed by the per-line sample count:
//     fine_dout = x*(2^FRAC_WD - f) + p*f
//   computed as (x << FRAC_WD) + (p - x)*f over a fixed 3-stage pipeline.
//
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset (LUT contents are kept)
//     bus  fine_delay_interp_if.slave: sample stream in, line control,
//          LUT write port, interpolated sample out
//
//   FD_OUT_WD must equal INPUT_WD + FRAC_WD.
// ---------------------------------------------------------------------------
module fine_delay_interp #(
  parameter int INPUT_WD  = 14,
  parameter int FRAC_WD   = 4,
  parameter int ADDR_WD   = 12,
  parameter int FD_OUT_WD = 18
) (
  input  logic                clk,
  input  logic                rst,
  fine_delay_interp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, next_state;
  logic [1:0] flush_cnt;
  logic       acc;
  logic       enter_run;

  logic        [ADDR_WD-1:0]   rd_ptr;
  logic signed [INPUT_WD-1:0]  prev;

  logic        [FRAC_WD-1:0]   lut_mem [DEPTH];
  logic        [FRAC_WD-1:0]   lut_q;

  logic                        v1;
  logic signed [INPUT_WD-1:0]  x1;
  logic signed [INPUT_WD-1:0]  p1;

  logic                        v2;
  logic        [FRAC_WD-1:0]   frac2;
  logic signed [INPUT_WD:0]    d2;
  logic signed [FD_OUT_WD-1:0] xs2;

  logic                        v3;
  logic signed [FD_OUT_WD-1:0] dout3;

  assign acc       = (state == RUN) && bus.fine_din_valid && !bus.tx_en;
  assign enter_run = (state == IDLE) && (next_state == RUN);

  // Line control: RUN for the receive window, then a fixed 3-cycle FLUSH so
  // the pipeline drains before a new line may start. start is not looked at
  // during FLUSH.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start)         next_state = RUN;
      RUN:     if (!bus.start)        next_state = FLUSH;
      FLUSH:   if (flush_cnt == 2'd2) next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= 2'd0;
    end else begin
      state     <= next_state;
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
    end
  end

  // Sample counter and history restart with every line so the first sample
  // of a line uses LUT[0] and interpolates against zero.
  always_ff @(posedge clk) begin
    if (rst || enter_run) begin
      rd_ptr <= '0;
      prev   <= '0;
    end else if (acc) begin
      rd_ptr <= rd_ptr + ADDR_WD'(1);
      prev   <= bus.fine_din;
    end
  end

  // Fine-delay LUT. The read sits in the same block as the write so a
  // same-address collision returns the old contents (read-first).
  always_ff @(posedge clk) begin
    if (bus.lut_we) begin
      lut_mem[bus.lut_addr] <= bus.lut_din;
    end
    lut_q <= lut_mem[rd_ptr];
  end

  // S1 captures the accepted sample and its predecessor; the LUT read for
  // the same sample lands in lut_q on this edge as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      x1 <= '0;
      p1 <= '0;
    end else begin
      v1 <= acc;
      if (acc) begin
        x1 <= bus.fine_din;
        p1 <= prev;
      end
    end
  end

  // S2 forms the difference (one guard bit) and the scaled current sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      frac2 <= '0;
      d2    <= '0;
      xs2   <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        frac2 <= lut_q;
        d2    <= {p1[INPUT_WD-1], p1} - {x1[INPUT_WD-1], x1};
        xs2   <= {x1, {FRAC_WD{1'b0}}};
      end
    end
  end

  // S3: the intermediate product can exceed FD_OUT_WD, but the final sum
  // always lies between x<<F and p<<F, so modulo-2^FD_OUT_WD arithmetic
  // yields the exact result. The fraction is zero-extended.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3    <= 1'b0;
      dout3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        dout3 <= xs2 + FD_OUT_WD'(d2) * FD_OUT_WD'({1'b0, frac2});
      end
    end
  end

  assign bus.fine_dout       = dout3;
  assign bus.fine_dout_valid = v3;

endmodule

// File: tb/tb_fine_delay_interp.sv
// ---------------------------------------------------------------------------
// tb_fine_delay_interp
//   Directed bench for fine_delay_interp built with a 4-entry LUT
//   (ADDR_WD=2) so pointer wrap is reachable in a few samples. Stimulus pushes
//   hand-computed results and their due cycle into a scoreboard queue; a
//   negedge monitor pops and compares whenever fine_dout_valid is high.
// ---------------------------------------------------------------------------
module tb_fine_delay_interp;

  localparam int INPUT_WD  = 14;
  localparam int FRAC_WD   = 4;
  localparam int ADDR_WD   = 2;
  localparam int FD_OUT_WD = 18;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fine_delay_interp_if #(
    .INPUT_WD(INPUT_WD), .FRAC_WD(FRAC_WD),
    .ADDR_WD(ADDR_WD), .FD_OUT_WD(FD_OUT_WD)
  ) bus ();

  fine_delay_interp #(
    .INPUT_WD(INPUT_WD), .FRAC_WD(FRAC_WD),
    .ADDR_WD(ADDR_WD), .FD_OUT_WD(FD_OUT_WD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   nc       = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  bit   chk_rst  = 1'b0;
  bit   fin_req  = 1'b0;
  bit   fin_done = 1'b0;

  // Single place where comparisons are counted and reported.
  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, nc);
    end
  endtask

  // Monitor: counts negedges, checks reset state on request, pops the
  // scoreboard on every output pulse and finally checks nothing is pending.
  always @(negedge clk) begin
    exp_t e;
    nc <= nc + 1;
    if (chk_rst) begin
      checkOutput("reset_valid", int'(bus.fine_dout_valid), 0);
      checkOutput("reset_dout", int'(bus.fine_dout), 0);
    end
    if (bus.fine_dout_valid !== 1'b0) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_output", int'(bus.fine_dout_valid), 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("dout", int'(bus.fine_dout), e.val);
        checkOutput("latency", nc + 1, e.due);
      end
    end
    if (fin_req && !fin_done) begin
      checkOutput("pending_outputs", sb_q.size(), 0);
      fin_done <= 1'b1;
    end
  end

  // One clock of stimulus; if push is set the sample is known to be accepted
  // and its result is due three negedges later.
  task automatic applyStimulus(input bit st, input int din, input bit vld,
                               input bit tx, input bit push, input int exp_val);
    exp_t e;
    @(negedge clk);
    #1;
    rst                = 1'b0;
    chk_rst            = 1'b0;
    bus.lut_we         = 1'b0;
    bus.start          = st;
    bus.fine_din       = INPUT_WD'(din);
    bus.fine_din_valid = vld;
    bus.tx_en          = tx;
    if (push) begin
      e.val = exp_val;
      e.due = nc + 3;
      sb_q.push_back(e);
    end
  endtask

  task automatic writeLut(input int addr, input int val);
    @(negedge clk);
    #1;
    rst                = 1'b0;
    chk_rst            = 1'b0;
    bus.start          = 1'b0;
    bus.fine_din_valid = 1'b0;
    bus.tx_en          = 1'b0;
    bus.lut_we         = 1'b1;
    bus.lut_addr       = ADDR_WD'(addr);
    bus.lut_din        = FRAC_WD'(val);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst                = 1'b1;
    chk_rst            = 1'b1;
    bus.lut_we         = 1'b0;
    bus.fine_din_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.tx_en          = 1'b0;
    bus.fine_din       = '0;
    bus.fine_din_valid = 1'b0;
    bus.lut_addr       = '0;
    bus.lut_we         = 1'b0;
    bus.lut_din        = '0;

    doReset();
    idleCycles(2);

    // All-zero fractions: output is the sample itself scaled by 16.
    for (int i = 0; i < 4; i++) writeLut(i, 0);
    applyStimulus(1'b1, 0,    1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 100,  1'b1, 1'b0, 1'b1, 1600);
    applyStimulus(1'b1, -200, 1'b1, 1'b0, 1'b1, -3200);
    applyStimulus(1'b1, 300,  1'b1, 1'b0, 1'b1, 4800);
    idleCycles(6);

    // Half-sample delay; first sample interpolates against zero.
    for (int i = 0; i < 3; i++) writeLut(i, 8);
    applyStimulus(1'b1, 0,    1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 100,  1'b1, 1'b0, 1'b1, 800);
    applyStimulus(1'b1, 200,  1'b1, 1'b0, 1'b1, 2400);
    applyStimulus(1'b1, -100, 1'b1, 1'b0, 1'b1, 800);
    idleCycles(6);

    // Full-scale extremes with the largest fraction.
    writeLut(1, 15);
    applyStimulus(1'b1, 0,     1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, -8192, 1'b1, 1'b0, 1'b1, -65536);
    applyStimulus(1'b1, 8191,  1'b1, 1'b0, 1'b1, -114689);
    idleCycles(6);

    // tx_en blanking mid-line: pointer and history hold across the gap.
    writeLut(0, 0);
    writeLut(1, 4);
    writeLut(2, 8);
    writeLut(3, 12);
    applyStimulus(1'b1, 0,  1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16, 1'b1, 1'b0, 1'b1, 256);
    applyStimulus(1'b1, 32, 1'b1, 1'b0, 1'b1, 448);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 999, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 48, 1'b1, 1'b0, 1'b1, 640);
    applyStimulus(1'b1, 64, 1'b1, 1'b0, 1'b1, 832);
    idleCycles(6);

    // Pointer wrap over the 4-entry LUT, then a quick restart.
    applyStimulus(1'b1, 0,  1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 16, 1'b1, 1'b0, 1'b1, 256);
    applyStimulus(1'b1, 32, 1'b1, 1'b0, 1'b1, 448);
    applyStimulus(1'b1, 48, 1'b1, 1'b0, 1'b1, 640);
    applyStimulus(1'b1, 64, 1'b1, 1'b0, 1'b1, 832);
    applyStimulus(1'b1, 80, 1'b1, 1'b0, 1'b1, 1280);
    applyStimulus(1'b1, 96, 1'b1, 1'b0, 1'b1, 1472);
    // start low two cycles; samples offered during FLUSH/IDLE are dropped.
    applyStimulus(1'b0, 0,   1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 555, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 555, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 20, 1'b1, 1'b0, 1'b1, 320);
    applyStimulus(1'b1, 40, 1'b1, 1'b0, 1'b1, 560);

    // Reset with two samples in flight: they must never appear.
    applyStimulus(1'b1, 10, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 20, 1'b1, 1'b0, 1'b0, 0);
    doReset();
    applyStimulus(1'b1, 0,  1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 30, 1'b1, 1'b0, 1'b1, 480);
    applyStimulus(1'b1, 50, 1'b1, 1'b0, 1'b1, 720);
    idleCycles(8);

    fin_req = 1'b1;
    for (int i = 0; i < 5 && !fin_done; i++) @(negedge clk);
    if (!fin_done) begin
      $display("[TB] FAIL monitor_final: got no final check, expected one");
      $fatal(1, "[TB] monitor did not complete");
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
